// File: rtl/pc_ras_pkg.sv
// Shared constants and the PC update opcode for the program counter / return stack block.
package pc_ras_pkg;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned RAS_DEPTH = 8;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_SEQ    = 3'd1,
        OP_BRANCH = 3'd2,
        OP_JUMP   = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } pc_op_t;

endpackage

// File: rtl/pc_ras_stack.sv
// Circular LIFO of return addresses: push when full overwrites the oldest entry,
// pop when empty is ignored. Storage is not reset; top reads '0 while empty.
module ras_stack #(
    parameter int unsigned W     = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] sp_q, sp_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] sp_top;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign sp_top = sp_q - PW'(1);
    assign top    = empty ? '0 : mem_q[sp_top];

    // sp always points at the next free slot; it wraps mod DEPTH so an
    // overflowing push lands on the oldest entry.
    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        if (push) begin
            sp_d = sp_q + PW'(1);
            if (!full) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop && !empty) begin
            sp_d    = sp_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= '0;
            count_q <= '0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[sp_q] <= din;
        end
    end

endmodule

// File: rtl/pc_ras.sv
// Program counter with sequential/branch/jump/call/return updates, a hardware
// return-address stack and sticky overflow/underflow flags.
module pc_ras
    import pc_ras_pkg::*;
#(
    parameter int unsigned        ADDR_W    = pc_ras_pkg::ADDR_W,
    parameter int unsigned        RAS_DEPTH = pc_ras_pkg::RAS_DEPTH,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pc_we,
    input  logic [2:0]                   pc_op,
    input  logic [ADDR_W-1:0]            pc_off,
    input  logic [ADDR_W-1:0]            pc_target,
    input  logic                         err_clr,
    output logic [ADDR_W-1:0]            pc_curr,
    output logic [ADDR_W-1:0]            pc_inc,
    output logic [ADDR_W-1:0]            ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_full,
    output logic                         ras_empty,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push, pop;
    logic              ovf_set, unf_set;
    pc_op_t            op;

    assign op      = pc_op_t'(pc_op);
    assign pc_curr = pc_q;
    assign pc_inc  = pc_q + ADDR_W'(1);
    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;

    ras_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (ras_top),
        .count (ras_count),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (pc_we) begin
            case (op)
                OP_SEQ:    pc_d = pc_inc;
                OP_BRANCH: pc_d = pc_q + pc_off;
                OP_JUMP:   pc_d = pc_target;
                OP_CALL: begin
                    push    = 1'b1;
                    ovf_set = ras_full;
                    pc_d    = pc_target;
                end
                OP_RET: begin
                    if (ras_empty) begin
                        unf_set = 1'b1;
                        pc_d    = pc_inc;
                    end else begin
                        pop  = 1'b1;
                        pc_d = ras_top;
                    end
                end
                default: ;
            endcase
        end
        // A set event in the same cycle as err_clr keeps the flag high.
        ovf_d = ovf_set | (ovf_q & ~err_clr);
        unf_d = unf_set | (unf_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

endmodule
